tile_map_scheduler: RTL and testbench

Sequences the tile drawer across a full screen tile map. On each start it walks a MAP_W x MAP_H map RAM in row-major order and fetches each tile index. For each tile it issues one draw request with the tile's pixel origin and ROM base address, then waits for the drawer's done pulse before moving on. It sits between the game logic (start/busy) and a single tile_drawer instance.

---
 rtl/tile_pkg.sv | 30 +++
 rtl/tile_map_cursor.sv | 54 +++++
 rtl/tile_map_scheduler.sv | 110 +++++++++++
 tb/tb_tile_map_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared constants for the tile map scheduler and tile drawer: map geometry defaults,
// FSM state encoding and the tile ROM base helper.
package tile_pkg;

    localparam int unsigned TILE_PX        = 8;
    localparam int unsigned PX_SHIFT       = 3;
    localparam int unsigned DEF_MAP_W      = 20;
    localparam int unsigned DEF_MAP_H      = 15;
    localparam int unsigned TILE_SHIFT     = 6;
    localparam int unsigned DEF_MAP_AW     = 9;
    localparam int unsigned DEF_IDX_W      = 6;
    localparam int unsigned COL_W          = 5;
    localparam int unsigned ROW_W          = 4;
    localparam int unsigned TILES_W        = 9;
    localparam int unsigned ROM_AW         = 12;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_MAP  = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_ADVANCE   = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

    function automatic logic [ROM_AW-1:0] tile_base(input logic [ROM_AW-1:0] idx,
                                                    input int unsigned       shift);
        return idx << shift;
    endfunction

endpackage

// File: rtl/tile_map_cursor.sv
// Column/row/map address counters for the row-major walk over the tile map.
module tile_map_cursor
    import tile_pkg::*;
#(
    parameter int unsigned MAP_W  = DEF_MAP_W,
    parameter int unsigned MAP_H  = DEF_MAP_H,
    parameter int unsigned MAP_AW = DEF_MAP_AW
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_load,
    input  logic              i_advance,
    output logic [COL_W-1:0]  o_col,
    output logic [ROW_W-1:0]  o_row,
    output logic [MAP_AW-1:0] o_map_addr,
    output logic              o_last_tile
);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [MAP_AW-1:0] r_map_addr;
    logic              w_last_col;
    logic              w_last_row;

    assign w_last_col  = (r_col == COL_W'(MAP_W - 1));
    assign w_last_row  = (r_row == ROW_W'(MAP_H - 1));
    assign o_last_tile = w_last_col && w_last_row;

    // Advancing past the final tile is a no-op so map_addr finishes on the last address.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_col      <= '0;
            r_row      <= '0;
            r_map_addr <= '0;
        end else if (i_load) begin
            r_col      <= '0;
            r_row      <= '0;
            r_map_addr <= '0;
        end else if (i_advance && !o_last_tile) begin
            r_map_addr <= r_map_addr + 1'b1;
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_map_addr = r_map_addr;

endmodule

// File: rtl/tile_map_scheduler.sv
// Walks the tile map and issues one draw request per tile to the tile drawer.
// Optional macro SKIP_BLANK_EN: tiles with index 0 are skipped without a draw request.
module tile_map_scheduler
    import tile_pkg::*;
#(
    parameter int unsigned MAP_W      = DEF_MAP_W,
    parameter int unsigned MAP_H      = DEF_MAP_H,
    parameter int unsigned TILE_SHIFT = tile_pkg::TILE_SHIFT,
    parameter int unsigned MAP_AW     = DEF_MAP_AW,
    parameter int unsigned IDX_W      = DEF_IDX_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    output logic [MAP_AW-1:0]   map_addr,
    input  logic [IDX_W-1:0]    map_data,
    output logic [ROM_AW-1:0]   tile_address,
    output logic [7:0]          x_pos,
    output logic [7:0]          y_pos,
    output logic                draw,
    input  logic                drawer_done,
    output logic                busy,
    output logic                frame_done,
    output logic [TILES_W-1:0]  tiles_drawn
);

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [ROM_AW-1:0]   r_tile_address;
    logic [7:0]          r_x_pos;
    logic [7:0]          r_y_pos;
    logic [TILES_W-1:0]  r_tiles_drawn;
    logic [COL_W-1:0]    w_col;
    logic [ROW_W-1:0]    w_row;
    logic                w_last_tile;
    logic                w_load;
    logic                w_advance;
    logic                w_enter_issue;
    logic                w_blank;

`ifdef SKIP_BLANK_EN
    assign w_blank = (map_data == '0);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_next = S_FETCH;
            S_FETCH:     w_state_next = S_WAIT_MAP;
            S_WAIT_MAP:  w_state_next = w_blank ? S_ADVANCE : S_ISSUE;
            S_ISSUE:     w_state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (drawer_done) w_state_next = S_ADVANCE;
            S_ADVANCE:   w_state_next = w_last_tile ? S_FINISH : S_FETCH;
            S_FINISH:    w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    assign w_load        = (r_state == S_IDLE) && start;
    assign w_advance     = (r_state == S_ADVANCE);
    assign w_enter_issue = (r_state == S_WAIT_MAP) && (w_state_next == S_ISSUE);

    tile_map_cursor #(
        .MAP_W  (MAP_W),
        .MAP_H  (MAP_H),
        .MAP_AW (MAP_AW)
    ) u_cursor (
        .clk         (clk),
        .resetn      (resetn),
        .i_load      (w_load),
        .i_advance   (w_advance),
        .o_col       (w_col),
        .o_row       (w_row),
        .o_map_addr  (map_addr),
        .o_last_tile (w_last_tile)
    );

    // Draw parameters are captured straight from the RAM on entry to ISSUE, so they are
    // valid alongside the draw pulse and held until the next tile is issued.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_tile_address <= '0;
            r_x_pos        <= '0;
            r_y_pos        <= '0;
            r_tiles_drawn  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_tiles_drawn <= '0;
            end else if (w_enter_issue) begin
                r_tile_address <= tile_base(ROM_AW'(map_data), TILE_SHIFT);
                r_x_pos        <= 8'({w_col, 3'b000});
                r_y_pos        <= 8'({w_row, 3'b000});
                r_tiles_drawn  <= r_tiles_drawn + 1'b1;
            end
        end
    end

    assign tile_address = r_tile_address;
    assign x_pos        = r_x_pos;
    assign y_pos        = r_y_pos;
    assign tiles_drawn  = r_tiles_drawn;
    assign draw         = (r_state == S_ISSUE);
    assign busy         = (r_state != S_IDLE);
    assign frame_done   = (r_state == S_FINISH);

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Directed bench for tile_map_scheduler with a map RAM model and a fixed-latency drawer model.
module tb_tile_map_scheduler;

    localparam int unsigned BOUND = 6000;
`ifdef SKIP_BLANK_EN
    localparam int unsigned EXP_TILES = 150;
    localparam int unsigned EXP_CYC   = 1802;
    localparam int unsigned EXP_AT37  = 19;
    localparam int unsigned EXP_FIRST = 1;
    localparam int unsigned EXP_EVEN  = 0;
`else
    localparam int unsigned EXP_TILES = 300;
    localparam int unsigned EXP_CYC   = 2702;
    localparam int unsigned EXP_AT37  = 38;
    localparam int unsigned EXP_FIRST = 0;
    localparam int unsigned EXP_EVEN  = 150;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [8:0]  map_addr;
    logic [5:0]  map_data;
    logic [11:0] tile_address;
    logic [7:0]  x_pos;
    logic [7:0]  y_pos;
    logic        draw;
    logic        drawer_done;
    logic        busy;
    logic        frame_done;
    logic [8:0]  tiles_drawn;

    logic [5:0]  mem [512];
    logic        model_done = 1'b0;
    logic        inj_done;
    int          dcnt = 0;
    int          stop_addr;
    int          n_draw = 0;
    int          n_even = 0;
    int          n_fd = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    tile_map_scheduler u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .map_addr     (map_addr),
        .map_data     (map_data),
        .tile_address (tile_address),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .draw         (draw),
        .drawer_done  (drawer_done),
        .busy         (busy),
        .frame_done   (frame_done),
        .tiles_drawn  (tiles_drawn)
    );

    always @(posedge clk) map_data <= mem[map_addr];
    always @(posedge clk) cyc <= cyc + 1;

    assign drawer_done = model_done | inj_done;

    // Drawer answers 5 cycles after each draw, except for the tile at stop_addr.
    always @(negedge clk) begin
        model_done = 1'b0;
        if (dcnt != 0) begin
            dcnt = dcnt - 1;
            if (dcnt == 0) model_done = 1'b1;
        end else if (draw && (int'(map_addr) != stop_addr)) begin
            dcnt = 5;
        end
    end

    always @(negedge clk) begin
        if (draw) begin
            n_draw <= n_draw + 1;
            if (!map_addr[0]) n_even <= n_even + 1;
        end
        if (frame_done) n_fd <= n_fd + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_draw_at(input int addr, input string tag);
        int i;
        for (i = 0; i < BOUND && !(draw && int'(map_addr) == addr); i++) @(negedge clk);
        chk(tag, 32'(i < BOUND), 32'd1);
    endtask

    task automatic wait_frame_done(input string tag);
        int i;
        for (i = 0; i < BOUND && !frame_done; i++) @(negedge clk);
        chk(tag, 32'(i < BOUND), 32'd1);
    endtask

    task automatic pulse_start(output int start_cyc);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int st_cyc;
        int base_draw;
        int base_even;
        int base_fd;
        int i;

        for (int a = 0; a < 512; a++) begin
`ifdef SKIP_BLANK_EN
            mem[a] = (a % 2 == 0) ? 6'd0 : 6'(a % 64);
`else
            mem[a] = 6'(a % 64);
`endif
        end
        resetn    = 1'b0;
        start     = 1'b0;
        inj_done  = 1'b0;
        stop_addr = 37;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_draw", 32'(draw), 0);
        chk("rst_map_addr", 32'(map_addr), 0);
        chk("rst_tiles", 32'(tiles_drawn), 0);
        chk("rst_xyaddr", {4'd0, tile_address, x_pos, y_pos}, 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        resetn = 1'b1;
        @(negedge clk);

        // Pass stalls on tile 37 because the drawer never answers it, then is reset.
        pulse_start(st_cyc);
        chk("busy_after_start", 32'(busy), 1);
        wait_draw_at(37, "reach_tile37");
        repeat (2) @(negedge clk);
        chk("tiles_at37", 32'(tiles_drawn), EXP_AT37);
        chk("busy_at37", 32'(busy), 1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        stop_addr = 999;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_draw", 32'(draw), 0);
        chk("midrst_map_addr", 32'(map_addr), 0);
        chk("midrst_tiles", 32'(tiles_drawn), 0);
        @(negedge clk);

        base_draw = n_draw;
        base_even = n_even;
        base_fd   = n_fd;
        pulse_start(st_cyc);
        for (i = 0; i < 20 && !draw; i++) @(negedge clk);
        chk("first_draw_addr", 32'(map_addr), EXP_FIRST);
        chk("first_draw_x", 32'(x_pos), 8 * EXP_FIRST);
        chk("first_draw_y", 32'(y_pos), 0);

        wait_draw_at(21, "reach_tile21");
        chk("t21_x", 32'(x_pos), 8);
        chk("t21_y", 32'(y_pos), 8);
        chk("t21_addr", 32'(tile_address), 32'h540);

        wait_draw_at(101, "reach_tile101");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Spurious done pulses in FETCH and WAIT_MAP of tile 151.
        for (i = 0; i < BOUND && map_addr != 9'd151; i++) @(negedge clk);
        chk("reach_fetch151", 32'(i < BOUND), 1);
        inj_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        inj_done = 1'b0;
        chk("issue151_draw", 32'(draw), 1);
        chk("issue151_addr", 32'(map_addr), 151);
        repeat (3) @(negedge clk);
        chk("wait151_busy", 32'(busy), 1);
        chk("wait151_addr", 32'(map_addr), 151);
        chk("wait151_draw", 32'(draw), 0);

        wait_draw_at(299, "reach_tile299");
        chk("t299_x", 32'(x_pos), 152);
        chk("t299_y", 32'(y_pos), 112);
        chk("t299_addr", 32'(tile_address), 2752);

        wait_frame_done("frame_done_pass");
        chk("pass_cycles", 32'(cyc - st_cyc + 1), EXP_CYC);
        chk("fd_busy", 32'(busy), 1);
        chk("fd_map_addr", 32'(map_addr), 299);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("after_fd_busy", 32'(busy), 0);
        chk("after_fd_frame_done", 32'(frame_done), 0);
        repeat (3) @(negedge clk);
        chk("no_second_pass", 32'(busy), 0);
        chk("pass_tiles", 32'(tiles_drawn), EXP_TILES);
        chk("pass_draws", 32'(n_draw - base_draw), EXP_TILES);
        chk("pass_even_draws", 32'(n_even - base_even), EXP_EVEN);
        chk("pass_fd_pulses", 32'(n_fd - base_fd), 1);

        // Start held from FINISH into the first IDLE cycle is accepted.
        pulse_start(st_cyc);
        wait_frame_done("frame_done_pass2");
        start = 1'b1;
        @(negedge clk);
        chk("idle_busy_pass3", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        chk("pass3_busy", 32'(busy), 1);
        chk("pass3_tiles_clr", 32'(tiles_drawn), 0);
        base_draw = n_draw;
        wait_frame_done("frame_done_pass3");
        chk("pass3_tiles", 32'(tiles_drawn), EXP_TILES);
        @(negedge clk);
        chk("pass3_draws", 32'(n_draw - base_draw), EXP_TILES);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
